xdisp_driver: RTL

Memory-mapped 4-digit seven-segment display driver. It sits directly downstream of the ALU result path on the PicoVersat data bus. The controller writes an 8-bit magnitude, a sign flag and a message code. The block converts the magnitude to BCD with a sequential double-dabble, holds the result in digit registers and time-multiplexes the four digits onto the board's `Disp`/`Disp_sel` pins.

---
 rtl/xdisp_driver.sv | 252 +++++++++++++++++++++++++
 1 files changed

// File: rtl/xdisp_driver.sv
// xdisp_driver: 4-digit seven-segment driver with sequential double-dabble and digit scanning; DISP_DOT_EN adds a dp.
// Latency: write to digit registers 9 cycles; glyph visible once that digit is next scanned.
// Backpressure: none; writes while busy land in a one-deep, last-write-wins pending slot.
module xdisp_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [12:0] data_in,
  output logic        busy,
  output logic [7:0]  disp_value,
  output logic [3:0]  disp_select
);

  localparam logic [7:0] G_BLANK = 8'hFF;
  localparam logic [7:0] G_DASH  = 8'hBF;
  localparam logic [7:0] G_O     = 8'hC0;
  localparam logic [7:0] G_P     = 8'h8C;
  localparam logic [7:0] G_U     = 8'hC1;
  localparam logic [7:0] G_A     = 8'h88;
  localparam logic [7:0] G_L     = 8'hC7;
  localparam logic [7:0] G_E     = 8'h86;
  localparam logic [7:0] G_R     = 8'hAF;

`ifdef DISP_DOT_EN
  localparam int unsigned LW = 13;
`else
  localparam int unsigned LW = 11;
  logic dot_unused;
  assign dot_unused = ^data_in[12:11];
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            wr_acc;
  logic            start_new, start_pend, step_en, commit_en;

  logic [LW-1:0]   pend_q;
  logic            pend_vld_q;
  logic [LW-1:0]   src_dat;

  logic            cur_sign_q;
  logic [1:0]      cur_msg_q;
`ifdef DISP_DOT_EN
  logic [1:0]      cur_dot_q;
`endif
  logic [7:0]      mag_sh_q;
  logic [11:0]     bcd_q;
  logic [11:0]     bcd_adj;
  logic [11:0]     bcd_step;
  logic            carry_unused;
  logic [2:0]      step_q;

  logic [3:0][7:0] dig_q;
  logic [3:0][7:0] glyph;

  logic [15:0]     ref_cnt_q;
  logic [1:0]      idx_q;
  logic            ref_term;

  assign wr_acc = sel & we;

  function automatic logic [7:0] seg(input logic [3:0] n);
    logic [7:0] g;
    case (n)
      4'd0:    g = 8'hC0;
      4'd1:    g = 8'hF9;
      4'd2:    g = 8'hA4;
      4'd3:    g = 8'hB0;
      4'd4:    g = 8'h99;
      4'd5:    g = 8'h92;
      4'd6:    g = 8'h82;
      4'd7:    g = 8'hF8;
      4'd8:    g = 8'h80;
      4'd9:    g = 8'h90;
      default: g = G_BLANK;
    endcase
    return g;
  endfunction

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = wr_acc ? CONV : IDLE;
      CONV:    state_d = (step_q == 3'd7) ? COMMIT : CONV;
      COMMIT:  state_d = pend_vld_q ? CONV : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    start_new  = 1'b0;
    start_pend = 1'b0;
    step_en    = 1'b0;
    commit_en  = 1'b0;
    unique case (state_q)
      IDLE:   start_new = wr_acc;
      CONV: begin
        busy    = 1'b1;
        step_en = 1'b1;
      end
      COMMIT: begin
        busy       = 1'b1;
        commit_en  = 1'b1;
        start_pend = pend_vld_q;
      end
      default: ;
    endcase
  end

  // ---------------- conversion datapath ----------------
  assign src_dat = start_pend ? pend_q : data_in[LW-1:0];

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_step = {bcd_adj[10:0], mag_sh_q[7]};
  end

  // An 8-bit magnitude never reaches 1000, so nothing is lost off the top.
  assign carry_unused = bcd_adj[11];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_sign_q <= 1'b0;
      cur_msg_q  <= 2'b00;
`ifdef DISP_DOT_EN
      cur_dot_q  <= 2'b00;
`endif
      mag_sh_q   <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
    end else if (start_new || start_pend) begin
      cur_sign_q <= src_dat[8];
      cur_msg_q  <= src_dat[10:9];
`ifdef DISP_DOT_EN
      cur_dot_q  <= src_dat[12:11];
`endif
      mag_sh_q   <= src_dat[7:0];
      bcd_q      <= '0;
      step_q     <= '0;
    end else if (step_en) begin
      bcd_q      <= bcd_step;
      mag_sh_q   <= {mag_sh_q[6:0], 1'b0};
      step_q     <= step_q + 3'd1;
    end
  end

  // A write landing on the COMMIT edge refills the slot as the old entry drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else if (wr_acc && (state_q != IDLE)) begin
      pend_q     <= data_in[LW-1:0];
      pend_vld_q <= 1'b1;
    end else if (start_pend) begin
      pend_vld_q <= 1'b0;
    end
  end

  // ---------------- glyph composition ----------------
  always_comb begin
    glyph = {4{G_BLANK}};
    unique case (cur_msg_q)
      2'b00: begin
        glyph[0] = seg(bcd_q[3:0]);
        glyph[1] = ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0)) ? G_BLANK : seg(bcd_q[7:4]);
        glyph[2] = (bcd_q[11:8] == 4'd0) ? G_BLANK : seg(bcd_q[11:8]);
        glyph[3] = cur_sign_q ? G_DASH : G_BLANK;
      end
      2'b01: begin
        glyph[2] = G_O;
        glyph[1] = G_P;
      end
      2'b10: begin
        glyph[2] = G_U;
        glyph[1] = G_A;
        glyph[0] = G_L;
      end
      2'b11: begin
        glyph[2] = G_E;
        glyph[1] = G_R;
        glyph[0] = G_R;
      end
      default: ;
    endcase
`ifdef DISP_DOT_EN
    if (cur_dot_q == 2'b01) begin
      glyph[1][7] = 1'b0;
    end else if (cur_dot_q == 2'b10) begin
      glyph[2][7] = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_q <= {4{G_BLANK}};
    end else if (commit_en) begin
      dig_q <= glyph;
    end
  end

  // ---------------- digit scanning ----------------
  assign ref_term = (ref_cnt_q == 16'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ref_cnt_q <= '0;
      idx_q     <= '0;
    end else if (ref_term) begin
      ref_cnt_q <= '0;
      idx_q     <= idx_q + 2'd1;
    end else begin
      ref_cnt_q <= ref_cnt_q + 16'd1;
    end
  end

  // Select and segments share one register stage so they always switch together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_select <= 4'b1110;
      disp_value  <= G_BLANK;
    end else begin
      disp_select <= ~(4'b0001 << idx_q);
      disp_value  <= dig_q[idx_q];
    end
  end

endmodule
